// File: rtl/nash_cipher_core.sv
// Bit-serial table-driven stream cipher core.
// One byte in, eight table-stepped bit cycles, one byte out.
module nash_cipher_core #(
  parameter logic [7:0] KEY_INDEX = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] tbl_index,
  input  logic [7:0] tbl_red_next,
  input  logic       tbl_red_transform,
  input  logic [7:0] tbl_blue_next,
  input  logic       tbl_blue_transform,
  input  logic       key_load,
  input  logic [7:0] key_index,
  input  logic       mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] idx_q;
  logic [7:0] in_sr_q;
  logic [7:0] out_sr_q;
  logic [2:0] cnt_q;
  logic       mode_q;

  logic       accept;
  logic       x_bit;
  logic       k_bit;
  logic       r_bit;
  logic       s_bit;
  logic [7:0] idx_step;

  // Handshake and status outputs decoded from the FSM state.
  always_comb begin
    in_ready  = (state_q == IDLE) && !key_load;
    out_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
    accept    = in_valid && in_ready;
    tbl_index = idx_q;
    out_data  = out_sr_q;
  end

  // One cipher bit: keystream, result, ciphertext-select and next index.
  always_comb begin
    x_bit    = in_sr_q[7];
    k_bit    = tbl_red_transform ^ tbl_blue_transform;
    r_bit    = x_bit ^ k_bit;
    s_bit    = mode_q ? x_bit : r_bit;
    idx_step = s_bit ? tbl_blue_next : tbl_red_next;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd7) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: key load, byte capture and per-bit stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= KEY_INDEX;
      in_sr_q  <= 8'd0;
      out_sr_q <= 8'd0;
      cnt_q    <= 3'd0;
      mode_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_load) begin
            idx_q <= key_index;
          end else if (in_valid) begin
            in_sr_q <= in_data;
            mode_q  <= mode;
            cnt_q   <= 3'd0;
          end
        end
        SHIFT: begin
          idx_q    <= idx_step;
          out_sr_q <= {out_sr_q[6:0], r_bit};
          in_sr_q  <= {in_sr_q[6:0], 1'b0};
          cnt_q    <= cnt_q + 3'd1;
        end
        HOLD: begin
          idx_q <= idx_q;
        end
        default: begin
          idx_q <= idx_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nash_cipher_core.sv
// Self-checking bench for nash_cipher_core.
// Scoreboard queues hold expected bytes and table indices.
module tb_nash_cipher_core;

  localparam logic [7:0] KEY = 8'd0;

  logic       clk;
  logic       rst_n;
  logic [7:0] tbl_index;
  logic [7:0] tbl_red_next;
  logic       tbl_red_transform;
  logic [7:0] tbl_blue_next;
  logic       tbl_blue_transform;
  logic       key_load;
  logic [7:0] key_index;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_checks;
  int n_fail;

  logic [7:0] model_idx;
  logic [7:0] exp_data_q[$];
  logic [7:0] exp_idx_q[$];

  nash_cipher_core #(.KEY_INDEX(KEY)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .tbl_index          (tbl_index),
    .tbl_red_next       (tbl_red_next),
    .tbl_red_transform  (tbl_red_transform),
    .tbl_blue_next      (tbl_blue_next),
    .tbl_blue_transform (tbl_blue_transform),
    .key_load           (key_load),
    .key_index          (key_index),
    .mode               (mode),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .busy               (busy)
  );

  assign tbl_red_next       = tbl_index + 8'd1;
  assign tbl_blue_next      = tbl_index + 8'd2;
  assign tbl_red_transform  = tbl_index[0];
  assign tbl_blue_transform = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] model(
    input logic [7:0] idx_in,
    input logic [7:0] d,
    input logic       m
  );
    logic [7:0] idx;
    logic [7:0] o;
    logic x, k, r, s;
    idx = idx_in;
    o   = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      x   = d[i];
      k   = idx[0] ^ 1'b0;
      r   = x ^ k;
      s   = m ? x : r;
      idx = s ? idx + 8'd2 : idx + 8'd1;
      o   = {o[6:0], r};
    end
    return {idx, o};
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic m);
    logic [15:0] res;
    res = model(model_idx, d, m);
    model_idx = res[15:8];
    exp_data_q.push_back(res[7:0]);
    exp_idx_q.push_back(res[15:8]);
  endtask

  task automatic send(input logic [7:0] d, input logic m);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    push_exp(d, m);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hXX;
    mode     = 1'b0;
  endtask

  task automatic recv(input int hold_cycles);
    int cycles;
    logic [7:0] ed, ei, held;
    cycles = 1;
    while (!out_valid && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (cycles != 9 || !out_valid) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles valid=%0b required 9",
               cycles, out_valid);
    end
    ed = exp_data_q.pop_front();
    ei = exp_idx_q.pop_front();
    n_checks++;
    if (out_data !== ed) begin
      n_fail++;
      $display("FAIL out_data: got %h required %h", out_data, ed);
    end
    n_checks++;
    if (tbl_index !== ei) begin
      n_fail++;
      $display("FAIL tbl_index: got %h required %h", tbl_index, ei);
    end
    held = out_data;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold: v=%0b d=%h rdy=%0b busy=%0b required 1 %h 0 1",
                 out_valid, out_data, in_ready, busy, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: v=%0b busy=%0b rdy=%0b required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_idx = KEY;
    exp_data_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        in_ready !== 1'b1 || tbl_index !== KEY) begin
      n_fail++;
      $display("FAIL reset: busy=%0b v=%0b d=%h rdy=%0b idx=%h req 0 0 00 1 %h",
               busy, out_valid, out_data, in_ready, tbl_index, KEY);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt();
    send(8'h00, 1'b0);
    n_checks++;
    if (exp_data_q[0] !== 8'h7F || exp_idx_q[0] !== 8'd15) begin
      n_fail++;
      $display("FAIL enc_model: got %h/%0d required 7f/15",
               exp_data_q[0], exp_idx_q[0]);
    end
    recv(0);
  endtask

  task automatic test_decrypt();
    do_reset();
    send(8'h7F, 1'b1);
    recv(0);
    n_checks++;
    if (tbl_index !== 8'd15) begin
      n_fail++;
      $display("FAIL dec_idx: got %0d required 15", tbl_index);
    end
  endtask

  task automatic test_backpressure();
    send(8'hC3, 1'b0);
    recv(5);
  endtask

  task automatic test_key_load(input logic [7:0] k);
    key_load  = 1'b1;
    key_index = k;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL key_rdy: in_ready=%0b required 0", in_ready);
    end
    @(negedge clk);
    key_load = 1'b0;
    in_valid = 1'b0;
    model_idx = k;
    n_checks++;
    if (tbl_index !== k || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL key_load: idx=%h busy=%0b required %h 0",
               tbl_index, busy, k);
    end
    send(8'h3C, 1'b0);
    recv(0);
  endtask

  task automatic test_reset_abort();
    bit seen;
    send(8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || tbl_index !== KEY || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%0b idx=%h v=%0b required 0 %h 0",
               busy, tbl_index, out_valid, KEY);
    end
    exp_data_q.delete();
    exp_idx_q.delete();
    model_idx = KEY;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_out: activity=%0b required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [7:0] b[N];
    logic       m[N];
    int hs_q[$];
    int sent, got, cyc, last;
    logic [7:0] ed, ei;
    for (int i = 0; i < N; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      m[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = b[0];
    mode      = m[0];
    sent = 0; got = 0; cyc = 0; last = 0;
    while (got < N && cyc < 200) begin
      if (!in_ready) begin
        if (sent < N) begin
          in_data = b[sent];
          mode    = m[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        ed = exp_data_q.pop_front();
        ei = exp_idx_q.pop_front();
        n_checks++;
        if (out_data !== ed || tbl_index !== ei ||
            cyc - hs_q[0] != 9) begin
          n_fail++;
          $display("FAIL b2b_out: d=%h idx=%h lat=%0d required %h %h 9",
                   out_data, tbl_index, cyc - hs_q[0], ed, ei);
        end
        void'(hs_q.pop_front());
        got++;
      end
      if (in_ready && in_valid) begin
        push_exp(b[sent], m[sent]);
        hs_q.push_back(cyc);
        if (sent > 0) begin
          n_checks++;
          if (cyc - last != 10) begin
            n_fail++;
            $display("FAIL b2b_rate: interval %0d required 10", cyc - last);
          end
        end
        last = cyc;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (got != N) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d required %0d", got, N);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_idx = KEY;
    rst_n     = 1'b0;
    key_load  = 1'b0;
    key_index = 8'h00;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_key_load(8'h20);
    test_reset_abort();
    test_key_load(8'hFB);
    test_back_to_back();
    n_checks++;
    if (exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d left required 0", exp_data_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
